// File: rtl/mem_wait_ram_if.sv
// Request/response bundle for the wait-state memory slave.
// Signal names keep the slave's point of view (_i into the memory, _o out of it).
interface mem_wait_ram_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int MEM_WIDTH  = 32
);
   logic                   valid_i;
   logic                   wr_rd_en_i;
   logic [ADDR_WIDTH-1:0]  addr_i;
   logic [MEM_WIDTH-1:0]   wdata_i;
   logic [MEM_WIDTH/8-1:0] wstrb_i;
   logic                   ready_o;
   logic [MEM_WIDTH-1:0]   rdata_o;
   logic                   rvalid_o;
   logic                   done_o;
   logic                   err_o;

   modport master (
      output valid_i, wr_rd_en_i, addr_i, wdata_i, wstrb_i,
      input  ready_o, rdata_o, rvalid_o, done_o, err_o
   );

   modport slave (
      input  valid_i, wr_rd_en_i, addr_i, wdata_i, wstrb_i,
      output ready_o, rdata_o, rvalid_o, done_o, err_o
   );
endinterface

// File: rtl/mem_wait_ram.sv
// Single-port memory slave with byte strobes, programmable wait states and
// a done/rvalid/err response; one transaction in flight at a time.
module mem_wait_ram #(
   parameter int ADDR_WIDTH  = 6,
   parameter int MEM_WIDTH   = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   mem_wait_ram_if.slave bus
);
   localparam int NB = MEM_WIDTH / 8;

   typedef enum logic {IDLE, BUSY} state_e;

   state_e                 state_q;
   logic                   ready_q;
   logic                   rvalid_q;
   logic                   done_q;
   logic                   err_q;
   logic                   wr_q;
   logic [3:0]             cnt_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [MEM_WIDTH-1:0]   wdata_q;
   logic [NB-1:0]          wstrb_q;
   logic [MEM_WIDTH-1:0]   rdata_q;
   logic [MEM_WIDTH-1:0]   mem_q [DEPTH];

   logic                   in_range_d;
   logic                   access_d;
   logic [MEM_WIDTH-1:0]   merged_d;
   logic [MEM_WIDTH-1:0]   rword_d;

   assign in_range_d = 32'(addr_q) < 32'(DEPTH);
   assign access_d   = (state_q == BUSY) && (cnt_q == '0);

   // Out-of-range accesses never index the array: reads return zero.
   always_comb begin
      rword_d  = '0;
      merged_d = '0;
      if (in_range_d) begin
         rword_d = mem_q[addr_q];
      end
      for (int unsigned k = 0; k < NB; k++) begin
         merged_d[8*k +: 8] = wstrb_q[k] ? wdata_q[8*k +: 8] : rword_d[8*k +: 8];
      end
   end

   // Storage is never cleared; reset only blocks a pending commit.
   always_ff @(posedge clk_i) begin
      if (!rst_i && access_d && wr_q && in_range_d) begin
         mem_q[addr_q] <= merged_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         ready_q  <= 1'b1;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
      end else begin
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.valid_i && ready_q) begin
                  wr_q    <= bus.wr_rd_en_i;
                  addr_q  <= bus.addr_i;
                  wdata_q <= bus.wdata_i;
                  wstrb_q <= bus.wstrb_i;
                  cnt_q   <= 4'(WAIT_CYCLES);
                  ready_q <= 1'b0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  done_q  <= 1'b1;
                  err_q   <= !in_range_d;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
                  if (!wr_q) begin
                     rvalid_q <= 1'b1;
                     rdata_q  <= rword_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ready_o  = ready_q;
   assign bus.rdata_o  = rdata_q;
   assign bus.rvalid_o = rvalid_q;
   assign bus.done_o   = done_q;
   assign bus.err_o    = err_q;
endmodule

// File: tb/tb_mem_wait_ram.sv
// Scoreboard bench: dut_a (DEPTH 40, 2 wait states) and dut_b (DEPTH 64, no wait states).
module tb_mem_wait_ram;
   typedef struct {
      bit          is_rd;
      bit          err;
      logic [31:0] rdata;
      int unsigned acc;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_a;
   logic        rst_b;
   int unsigned cyc = 0;
   int          checks = 0;
   int          passed = 0;
   exp_t        q_a[$];
   exp_t        q_b[$];
   logic [31:0] last_rd [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_wait_ram_if ifa ();
   mem_wait_ram_if ifb ();

   mem_wait_ram #(.ADDR_WIDTH(6), .MEM_WIDTH(32), .DEPTH(40), .WAIT_CYCLES(2)) dut_a (
      .clk_i(clk), .rst_i(rst_a), .bus(ifa.slave));
   mem_wait_ram #(.ADDR_WIDTH(6), .MEM_WIDTH(32), .DEPTH(64), .WAIT_CYCLES(0)) dut_b (
      .clk_i(clk), .rst_i(rst_b), .bus(ifb.slave));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
   endtask

   task automatic push(input int id, input exp_t e);
      if (id == 0) q_a.push_back(e);
      else q_b.push_back(e);
   endtask

   task automatic monitor(virtual mem_wait_ram_if vif, input int id, input int unsigned lat);
      exp_t e;
      int   sz;
      forever begin
         @(negedge clk);
         if (vif.done_o) begin
            sz = (id == 0) ? q_a.size() : q_b.size();
            if (sz == 0) begin
               check($sformatf("unexpected_done[%0d]", id), 32'(vif.done_o), 32'd0);
            end else begin
               if (id == 0) e = q_a.pop_front();
               else e = q_b.pop_front();
               check({e.name, "/err"}, 32'(vif.err_o), 32'(e.err));
               check({e.name, "/rvalid"}, 32'(vif.rvalid_o), 32'(e.is_rd));
               check({e.name, "/rdata"}, vif.rdata_o, e.rdata);
               check({e.name, "/latency"}, cyc - e.acc, lat);
            end
         end else if (vif.rvalid_o || vif.err_o) begin
            check($sformatf("stray_pulse[%0d]", id), 32'({vif.rvalid_o, vif.err_o}), 32'd0);
         end
      end
   endtask

   // Issues one request from a negedge and returns at the negedge where ready is back.
   task automatic xfer(virtual mem_wait_ram_if vif, input int id, input bit wr,
                       input logic [5:0] addr, input logic [31:0] wd, input logic [3:0] strb,
                       input logic [31:0] rexp, input string name);
      exp_t        e;
      int unsigned n;
      int unsigned wt;
      int unsigned depth;
      wt    = (id == 0) ? 2 : 0;
      depth = (id == 0) ? 40 : 64;
      n = 0;
      while (!vif.ready_o && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!vif.ready_o) begin
         check({name, "/ready_timeout"}, 32'(vif.ready_o), 32'd1);
         return;
      end
      vif.valid_i    = 1'b1;
      vif.wr_rd_en_i = wr;
      vif.addr_i     = addr;
      vif.wdata_i    = wd;
      vif.wstrb_i    = strb;
      @(negedge clk);
      vif.valid_i = 1'b0;
      vif.addr_i  = 6'h3F;
      vif.wdata_i = 32'hFFFF_FFFF;
      vif.wstrb_i = 4'hF;
      e.is_rd = !wr;
      e.err   = (32'(addr) >= depth);
      e.rdata = wr ? last_rd[id] : (e.err ? 32'd0 : rexp);
      e.acc   = cyc;
      e.name  = name;
      if (!wr) last_rd[id] = e.rdata;
      push(id, e);
      n = 0;
      while (!vif.ready_o && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({name, "/ready_low"}, n, wt + 1);
   endtask

   initial begin
      fork
         monitor(ifa, 0, 3);
         monitor(ifb, 1, 1);
      join_none
   end

   initial begin
      logic [31:0] sv [4];
      exp_t        e;
      int unsigned prev;
      int unsigned n;
      sv = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004};
      last_rd[0] = '0;
      last_rd[1] = '0;
      prev = 0;
      ifa.valid_i = 1'b0; ifa.wr_rd_en_i = 1'b0; ifa.addr_i = '0; ifa.wdata_i = '0; ifa.wstrb_i = '0;
      ifb.valid_i = 1'b0; ifb.wr_rd_en_i = 1'b0; ifb.addr_i = '0; ifb.wdata_i = '0; ifb.wstrb_i = '0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (2) @(negedge clk);
      check("reset/ready", 32'(ifa.ready_o), 32'd1);
      check("reset/rdata", ifa.rdata_o, 32'd0);
      check("reset/rvalid", 32'(ifa.rvalid_o), 32'd0);
      check("reset/done", 32'(ifa.done_o), 32'd0);
      check("reset/err", 32'(ifa.err_o), 32'd0);
      check("reset_b/ready", 32'(ifb.ready_o), 32'd1);
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);

      xfer(ifa, 0, 1, 6'd0,  32'h0102_0304, 4'hF, 32'd0, "wr0");
      xfer(ifa, 0, 1, 6'd39, 32'hCAFE_F00D, 4'hF, 32'd0, "wr39");
      xfer(ifa, 0, 1, 6'd7,  32'h0BAD_F00D, 4'hF, 32'd0, "wr7");
      xfer(ifa, 0, 1, 6'd5,  32'hDEAD_BEEF, 4'hF, 32'd0, "wr5_full");
      xfer(ifa, 0, 0, 6'd5,  32'd0, 4'h0, 32'hDEAD_BEEF, "rd5_full");
      xfer(ifa, 0, 1, 6'd5,  32'h1122_3344, 4'h5, 32'd0, "wr5_part");
      xfer(ifa, 0, 0, 6'd5,  32'd0, 4'h0, 32'hDE22_BE44, "rd5_part");
      xfer(ifa, 0, 1, 6'd5,  32'h0000_0000, 4'h0, 32'd0, "wr5_nostrb");
      xfer(ifa, 0, 0, 6'd5,  32'd0, 4'h0, 32'hDE22_BE44, "rd5_nostrb");
      xfer(ifa, 0, 1, 6'd45, 32'hFFFF_FFFF, 4'hF, 32'd0, "wr45_oor");
      xfer(ifa, 0, 0, 6'd45, 32'd0, 4'h0, 32'd0, "rd45_oor");
      xfer(ifa, 0, 0, 6'd0,  32'd0, 4'h0, 32'h0102_0304, "rd0_after_oor");
      xfer(ifa, 0, 0, 6'd39, 32'd0, 4'h0, 32'hCAFE_F00D, "rd39_after_oor");
      xfer(ifa, 0, 0, 6'd5,  32'd0, 4'h0, 32'hDE22_BE44, "rd5_after_oor");

      // Aborted write: reset lands one edge after the accept edge.
      ifa.valid_i = 1'b1; ifa.wr_rd_en_i = 1'b1; ifa.addr_i = 6'd7;
      ifa.wdata_i = 32'hA5A5_A5A5; ifa.wstrb_i = 4'hF;
      @(negedge clk);
      ifa.valid_i = 1'b0;
      check("abort/accepted", 32'(ifa.ready_o), 32'd0);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      last_rd[0] = '0;
      check("abort/ready", 32'(ifa.ready_o), 32'd1);
      check("abort/rdata", ifa.rdata_o, 32'd0);
      check("abort/done", 32'(ifa.done_o), 32'd0);
      check("abort/rvalid", 32'(ifa.rvalid_o), 32'd0);
      check("abort/err", 32'(ifa.err_o), 32'd0);
      repeat (4) @(negedge clk);
      xfer(ifa, 0, 0, 6'd7, 32'd0, 4'h0, 32'h0BAD_F00D, "rd7_after_abort");

      // Streaming with valid held high; inputs change while busy and must be ignored.
      ifb.valid_i = 1'b1; ifb.wr_rd_en_i = 1'b1; ifb.addr_i = 6'd0;
      ifb.wdata_i = sv[0]; ifb.wstrb_i = 4'hF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("stream%0d/accepted", i), 32'(ifb.ready_o), 32'd0);
         if (i > 0) check($sformatf("stream%0d/spacing", i), cyc - prev, 32'd2);
         prev    = cyc;
         e.is_rd = 1'b0;
         e.err   = 1'b0;
         e.rdata = 32'd0;
         e.acc   = cyc;
         e.name  = $sformatf("stream_wr%0d", i);
         push(1, e);
         if (i < 3) begin
            ifb.addr_i  = 6'(i + 1);
            ifb.wdata_i = sv[i + 1];
         end else begin
            ifb.valid_i = 1'b0;
         end
         @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         xfer(ifb, 1, 0, 6'(i), 32'd0, 4'h0, sv[i], $sformatf("stream_rd%0d", i));
      end

      n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("drain_a", q_a.size(), 32'd0);
      check("drain_b", q_b.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
